aurora_link_ctrl: RTL

Bring-up and recovery sequencer for the 4-lane QSFP Aurora 64b/66b link on the U250 FireSim shell. It drives the core's reset_pb and pma_init in the vendor-required order and waits for channel_up. It retries on timeout and restarts the link on a persistent drop or a hard error. It exposes link status and saturating event counters to the shell CSR block.

---
 rtl/aurora_ctrl_pkg.sv | 54 +++++
 rtl/aurora_ctrl_sat_cnt.sv | 40 ++++
 rtl/aurora_link_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/aurora_ctrl_pkg.sv
// Shared types, default parameters and helpers for the Aurora link bring-up sequencer.
package aurora_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_OFF  = 3'd0,
      ST_PB   = 3'd1,
      ST_PMA  = 3'd2,
      ST_TAIL = 3'd3,
      ST_WAIT = 3'd4,
      ST_UP   = 3'd5,
      ST_FAIL = 3'd6
   } state_e;

   typedef struct packed {
      logic reset_pb;
      logic pma_init;
      logic link_ok;
      logic link_fail;
   } ctrl_out_t;

   localparam int DEF_LANES      = 4;
   localparam int DEF_PB_LEAD    = 128;
   localparam int DEF_PMA_HOLD   = 1024;
   localparam int DEF_PB_TAIL    = 128;
   localparam int DEF_UP_TIMEOUT = 65536;
   localparam int DEF_DEBOUNCE   = 16;
   localparam int DEF_MAX_RETRY  = 7;
   localparam int DEF_CNT_W      = 16;

   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
      return (value >= max_value) ? max_value : value + 32'd1;
   endfunction

   // Cycle counter width: enough bits to hold (largest cycle parameter - 1), never below 1.
   function automatic int cnt_bits(input int a, input int b, input int c, input int d, input int e);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

   function automatic ctrl_out_t decode_outputs(input state_e s);
      ctrl_out_t o;
      o.reset_pb  = (s != ST_WAIT) && (s != ST_UP);
      o.pma_init  = (s == ST_PMA);
      o.link_ok   = (s == ST_UP);
      o.link_fail = (s == ST_FAIL);
      return o;
   endfunction

endpackage

// File: rtl/aurora_ctrl_sat_cnt.sv
// Event counter that sticks at all-ones instead of wrapping.
module aurora_ctrl_sat_cnt
   import aurora_ctrl_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Wraps to all-ones for W=32, which is exactly the saturation value.
   localparam logic [31:0] MAX_VALUE = (32'd1 << W) - 32'd1;

   logic [W-1:0] count_reg;
   logic [W-1:0] count_next;

   always_comb begin
      count_next = count_reg;
      if (inc) begin
         count_next = W'(sat_inc(32'(count_reg), MAX_VALUE));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count = count_reg;

   if (W < 1 || W > 32) begin : g_bad_width
      $error("aurora_ctrl_sat_cnt: W must be in 1..32");
   end

endmodule

// File: rtl/aurora_link_ctrl.sv
// Aurora 64b/66b bring-up/recovery sequencer: orders reset_pb/pma_init, waits for
// channel_up, retries on timeout and restarts on drops or hard errors.
module aurora_link_ctrl
   import aurora_ctrl_pkg::*;
#(
   parameter int LANES      = DEF_LANES,
   parameter int PB_LEAD    = DEF_PB_LEAD,
   parameter int PMA_HOLD   = DEF_PMA_HOLD,
   parameter int PB_TAIL    = DEF_PB_TAIL,
   parameter int UP_TIMEOUT = DEF_UP_TIMEOUT,
   parameter int DEBOUNCE   = DEF_DEBOUNCE,
   parameter int MAX_RETRY  = DEF_MAX_RETRY,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             restart,
   input  logic             channel_up,
   input  logic [LANES-1:0] lane_up,
   input  logic             hard_err,
   output logic             reset_pb,
   output logic             pma_init,
   output logic             link_ok,
   output logic             link_fail,
   output logic [2:0]       state,
   output logic [2:0]       retry_cnt,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [CNT_W-1:0] timeout_cnt
);

   localparam int CNT_BITS = cnt_bits(PB_LEAD, PMA_HOLD, PB_TAIL, UP_TIMEOUT, DEBOUNCE);

   localparam logic [CNT_BITS-1:0] PB_LAST   = CNT_BITS'(PB_LEAD - 1);
   localparam logic [CNT_BITS-1:0] PMA_LAST  = CNT_BITS'(PMA_HOLD - 1);
   localparam logic [CNT_BITS-1:0] TAIL_LAST = CNT_BITS'(PB_TAIL - 1);
   localparam logic [CNT_BITS-1:0] TO_LAST   = CNT_BITS'(UP_TIMEOUT - 1);
   localparam logic [CNT_BITS-1:0] DEB_LAST  = CNT_BITS'(DEBOUNCE - 1);
   localparam logic [31:0]         CNT_MAX   = (32'd1 << CNT_BITS) - 32'd1;
   localparam logic [2:0]          RETRY_MAX = 3'(MAX_RETRY);

   state_e              state_reg;
   state_e              state_next;
   logic [CNT_BITS-1:0] cnt_reg;
   logic [CNT_BITS-1:0] cnt_next;
   logic [2:0]          retry_reg;
   logic [2:0]          retry_next;
   ctrl_out_t           out_reg;
   logic                drop_inc;
   logic                timeout_inc;

   always_comb begin
      state_next  = state_reg;
      // Saturating so the long-dwell states (OFF, FAIL) can never wrap it.
      cnt_next    = CNT_BITS'(sat_inc(32'(cnt_reg), CNT_MAX));
      retry_next  = retry_reg;
      drop_inc    = 1'b0;
      timeout_inc = 1'b0;

      if (!en) begin
         if (state_reg != ST_OFF) begin
            state_next = ST_OFF;
            cnt_next   = '0;
         end
      end else if (restart) begin
         state_next = ST_PB;
         cnt_next   = '0;
         retry_next = '0;
      end else begin
         case (state_reg)
            ST_OFF: begin
               state_next = ST_PB;
               cnt_next   = '0;
               retry_next = '0;
            end
            ST_PB: begin
               if (cnt_reg == PB_LAST) begin
                  state_next = ST_PMA;
                  cnt_next   = '0;
               end
            end
            ST_PMA: begin
               if (cnt_reg == PMA_LAST) begin
                  state_next = ST_TAIL;
                  cnt_next   = '0;
               end
            end
            ST_TAIL: begin
               if (cnt_reg == TAIL_LAST) begin
                  state_next = ST_WAIT;
                  cnt_next   = '0;
               end
            end
            ST_WAIT: begin
               // A link that comes up on the last allowed cycle still counts as up.
               if (channel_up && (&lane_up)) begin
                  state_next = ST_UP;
                  cnt_next   = '0;
                  retry_next = '0;
               end else if (cnt_reg == TO_LAST) begin
                  timeout_inc = 1'b1;
                  retry_next  = retry_reg + 3'd1;
                  cnt_next    = '0;
                  state_next  = (retry_next == RETRY_MAX) ? ST_FAIL : ST_PB;
               end
            end
            ST_UP: begin
               if (hard_err) begin
                  state_next = ST_PB;
                  cnt_next   = '0;
                  drop_inc   = 1'b1;
               end else if (channel_up) begin
                  cnt_next = '0;
               end else if (cnt_reg == DEB_LAST) begin
                  state_next = ST_PB;
                  cnt_next   = '0;
                  drop_inc   = 1'b1;
               end
            end
            ST_FAIL: begin
               state_next = ST_FAIL;
            end
            default: begin
               state_next = ST_PB;
               cnt_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_PB;
         cnt_reg   <= '0;
         retry_reg <= '0;
         out_reg   <= decode_outputs(ST_PB);
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         retry_reg <= retry_next;
         out_reg   <= decode_outputs(state_next);
      end
   end

   logic [1:0]       ev_inc;
   logic [CNT_W-1:0] ev_count [2];

   assign ev_inc = {timeout_inc, drop_inc};

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_ev
      aurora_ctrl_sat_cnt #(
         .W (CNT_W)
      ) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (ev_inc[gi]),
         .count (ev_count[gi])
      );
   end

   assign drop_cnt    = ev_count[0];
   assign timeout_cnt = ev_count[1];
   assign reset_pb    = out_reg.reset_pb;
   assign pma_init    = out_reg.pma_init;
   assign link_ok     = out_reg.link_ok;
   assign link_fail   = out_reg.link_fail;
   assign state       = state_reg;
   assign retry_cnt   = retry_reg;

   if (PB_LEAD < 1 || PMA_HOLD < 1 || PB_TAIL < 1 || UP_TIMEOUT < 1 || DEBOUNCE < 1) begin : g_bad_cycles
      $error("aurora_link_ctrl: every cycle parameter must be >= 1");
   end
   if (MAX_RETRY < 1 || MAX_RETRY > 7) begin : g_bad_retry
      $error("aurora_link_ctrl: MAX_RETRY must be in 1..7");
   end
   if (LANES < 1) begin : g_bad_lanes
      $error("aurora_link_ctrl: LANES must be >= 1");
   end

endmodule
